// File: rtl/e_alu_mdu.sv
// Execute-stage ALU (combinational) plus multi-cycle multiply/divide unit with HI/LO.
// Optional: define MDU_MADD_EN to enable madd/maddu (md_op 6/7) accumulation into {HI,LO}.
module e_alu_mdu #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         A,
   input  logic [WIDTH-1:0]         B,
   input  logic [$clog2(WIDTH)-1:0] shamt,
   input  logic [3:0]               ALUop,
   output logic [WIDTH-1:0]         ALUresult,
   output logic                     overflow,
   input  logic                     start,
   input  logic [2:0]               md_op,
   output logic                     busy,
   output logic [WIDTH-1:0]         HI,
   output logic [WIDTH-1:0]         LO
);

   localparam int MAXLAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

   typedef enum logic {IDLE, RUN} state_e;
   typedef enum logic [2:0] {
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU
   } md_e;

   state_e           state;
   md_e              lop;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] la, lb;

   logic [WIDTH:0]   sum_x;

   always_comb begin
      ALUresult = '0;
      overflow  = 1'b0;
      sum_x     = '0;
      case (ALUop)
         4'd0: begin
            sum_x     = {A[WIDTH-1], A} + {B[WIDTH-1], B};
            ALUresult = sum_x[WIDTH-1:0];
            overflow  = sum_x[WIDTH] ^ sum_x[WIDTH-1];
         end
         4'd1: begin
            sum_x     = {A[WIDTH-1], A} - {B[WIDTH-1], B};
            ALUresult = sum_x[WIDTH-1:0];
            overflow  = sum_x[WIDTH] ^ sum_x[WIDTH-1];
         end
         4'd2:  ALUresult = B << (WIDTH / 2);
         4'd3:  ALUresult = A | B;
         4'd4:  ALUresult = A & B;
         4'd5:  ALUresult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'd6:  ALUresult = {{(WIDTH-1){1'b0}}, (A < B)};
         4'd7:  ALUresult = A ^ B;
         4'd8:  ALUresult = ~(A | B);
         4'd9:  ALUresult = B << shamt;
         4'd10: ALUresult = B >> shamt;
         4'd11: ALUresult = $unsigned($signed(B) >>> shamt);
         default: ALUresult = '0;
      endcase
   end

   logic [2*WIDTH-1:0] prod_s, prod_u, res;
   logic [WIDTH-1:0]   mag_a, mag_b, dvs, q_u, r_u, q, r;
   logic               sgn, neg_a, neg_b;

   // Signed divide works on magnitudes so that MIN/-1 wraps back to MIN with remainder 0.
   always_comb begin
      prod_s = {{WIDTH{la[WIDTH-1]}}, la} * {{WIDTH{lb[WIDTH-1]}}, lb};
      prod_u = {{WIDTH{1'b0}}, la} * {{WIDTH{1'b0}}, lb};
      sgn    = (lop == MD_DIV);
      neg_a  = sgn & la[WIDTH-1];
      neg_b  = sgn & lb[WIDTH-1];
      mag_a  = neg_a ? -la : la;
      mag_b  = neg_b ? -lb : lb;
      dvs    = (lb == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
      q_u    = mag_a / dvs;
      r_u    = mag_a % dvs;
      if (lb == '0) begin
         q = '1;
         r = la;
      end else begin
         q = (neg_a ^ neg_b) ? -q_u : q_u;
         r = neg_a ? -r_u : r_u;
      end
      case (lop)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV, MD_DIVU: res = {r, q};
`ifdef MDU_MADD_EN
         MD_MADD:  res = {HI, LO} + prod_s;
         MD_MADDU: res = {HI, LO} + prod_u;
`endif
         default:  res = {HI, LO};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         lop   <= MD_MULT;
         cnt   <= '0;
         la    <= '0;
         lb    <= '0;
         busy  <= 1'b0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (md_op)
                     3'd0, 3'd1
`ifdef MDU_MADD_EN
                     , 3'd6, 3'd7
`endif
                     : begin
                        la    <= A;
                        lb    <= B;
                        lop   <= md_e'(md_op);
                        cnt   <= CW'(MULT_CYCLES - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                     end
                     3'd2, 3'd3: begin
                        la    <= A;
                        lb    <= B;
                        lop   <= md_e'(md_op);
                        cnt   <= CW'(DIV_CYCLES - 1);
                        busy  <= 1'b1;
                        state <= RUN;
                     end
                     3'd4: HI <= A;
                     3'd5: LO <= A;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (cnt == '0) begin
                  HI    <= res[2*WIDTH-1:WIDTH];
                  LO    <= res[WIDTH-1:0];
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_e_alu_mdu.sv
// Randomised bench for e_alu_mdu against a plain-arithmetic reference model.
module tb_e_alu_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] A = '0, B = '0;
   logic [4:0]  shamt = '0;
   logic [3:0]  ALUop = '0;
   logic [31:0] ALUresult;
   logic        overflow;
   logic        start = 1'b0;
   logic [2:0]  md_op = '0;
   logic        busy;
   logic [31:0] HI, LO;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   e_alu_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .shamt(shamt), .ALUop(ALUop),
      .ALUresult(ALUresult), .overflow(overflow), .start(start), .md_op(md_op),
      .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
      longint sa, sb, s;
      logic [31:0] r;
      logic        v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0;
      v = 1'b0;
      case (op)
         4'd0, 4'd1: begin
            s = (op == 4'd0) ? sa + sb : sa - sb;
            r = s[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd2:  r = b * 32'd65536;
         4'd3:  r = a | b;
         4'd4:  r = a & b;
         4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd6:  r = (a < b) ? 32'd1 : 32'd0;
         4'd7:  r = a ^ b;
         4'd8:  r = ~(a | b);
         4'd9:  begin s = longint'(b) * (64'sd1 <<< sh); r = s[31:0]; end
         4'd10: r = b / (32'd1 << sh);
         4'd11: begin s = sb >>> sh; r = s[31:0]; end
         default: r = '0;
      endcase
      return {v, r};
   endfunction

   // Returns {latency, hi, lo} for an MDU command given current HI/LO.
   function automatic logic [71:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] p, acc;
      logic [31:0] nh, nl;
      int          lat;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      nh = hi; nl = lo; lat = 0;
      case (op)
         3'd0: begin p = sa * sb; {nh, nl} = p; lat = 5; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; lat = 5; end
         3'd2: begin
            lat = 10;
            if (b == 0) begin nl = 32'hFFFFFFFF; nh = a; end
            else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
         end
         3'd3: begin
            lat = 10;
            if (b == 0) begin nl = 32'hFFFFFFFF; nh = a; end
            else begin nl = a / b; nh = a % b; end
         end
         3'd4: nh = a;
         3'd5: nl = a;
`ifdef MDU_MADD_EN
         3'd6: begin p = sa * sb; acc = {hi, lo} + p; {nh, nl} = acc; lat = 5; end
         3'd7: begin p = {32'd0, a} * {32'd0, b}; acc = {hi, lo} + p; {nh, nl} = acc; lat = 5; end
`endif
         default: ;
      endcase
      return {8'(lat), nh, nl};
   endfunction

   task automatic alu_chk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
      logic [32:0] e;
      ALUop = op; A = a; B = b; shamt = sh;
      #1;
      e = alu_ref(op, a, b, sh);
      check($sformatf("alu_res_op%0d", op), 64'(ALUresult), 64'(e[31:0]));
      check($sformatf("alu_ovf_op%0d", op), 64'(overflow), 64'(e[32]));
   endtask

   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
      logic [71:0] e;
      int          n;
      @(negedge clk);
      A = a; B = b; md_op = op; start = 1'b1;
      e = md_ref(op, a, b, m_hi, m_lo);
      @(negedge clk);
      start = 1'b0; A = $urandom; B = $urandom;
      n = 0;
      while (busy && n < 200) begin
         check("hold_hi", 64'(HI), 64'(m_hi));
         check("hold_lo", 64'(LO), 64'(m_lo));
         n++;
         if (inject && n == 2) begin
            start = 1'b1; md_op = 3'd4; A = 32'h0000DEAD;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("busy_len_op%0d", op), 64'(n), 64'(e[71:64]));
      m_hi = e[63:32];
      m_lo = e[31:0];
      check($sformatf("hi_op%0d", op), 64'(HI), 64'(m_hi));
      check($sformatf("lo_op%0d", op), 64'(LO), 64'(m_lo));
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      int unsigned sel;

      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hi", 64'(HI), 64'd0);
      check("rst_lo", 64'(LO), 64'd0);
      reset = 1'b1;

      alu_chk(4'd0, 32'h7FFFFFFF, 32'd1, 5'd0);
      check("tp_add", 64'({overflow, ALUresult}), 64'h1_80000000);
      alu_chk(4'd1, 32'h80000000, 32'd1, 5'd0);
      check("tp_sub", 64'({overflow, ALUresult}), 64'h1_7FFFFFFF);
      alu_chk(4'd11, 32'h80000000, 32'h80000000, 5'd4);
      check("tp_sra", 64'(ALUresult), 64'hF8000000);
      for (int i = 0; i < 300; i++)
         alu_chk(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom));

      run_md(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
      check("tp_mult", 64'({HI, LO}), 64'hFFFFFFFF_FFFFFFEB);
      run_md(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0);
      check("tp_multu", 64'({HI, LO}), 64'h00000006_FFFFFFEB);
      run_md(3'd3, 32'd100, 32'd7, 1'b0);
      check("tp_divu", 64'({HI, LO}), 64'h00000002_0000000E);
      run_md(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
      check("tp_div", 64'({HI, LO}), 64'hFFFFFFFF_FFFFFFFD);
      run_md(3'd2, 32'h12345678, 32'd0, 1'b0);
      check("tp_div0", 64'({HI, LO}), 64'h12345678_FFFFFFFF);
      run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("tp_divmin", 64'({HI, LO}), 64'h00000000_80000000);
      run_md(3'd0, 32'd1234, 32'hFFFF0000, 1'b1);
      run_md(3'd5, 32'h55, 32'd0, 1'b0);
      check("tp_mtlo", 64'(LO), 64'h55);
      run_md(3'd6, 32'd9, 32'd9, 1'b0);
      run_md(3'd7, 32'hFFFFFFFF, 32'd2, 1'b0);

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 7);
         ra = $urandom; rb = $urandom;
         if (sel == 0) rb = '0;
         else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
         else if (sel == 2) rb = 32'($urandom_range(1, 9));
         run_md(rop, ra, rb, ($urandom_range(0, 3) == 0));
      end

      run_md(3'd4, 32'h77, 32'd0, 1'b0);
      run_md(3'd5, 32'h99, 32'd0, 1'b0);
      @(negedge clk);
      A = 32'd500; B = 32'd3; md_op = 3'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(HI), 64'd0);
      check("abort_lo", 64'(LO), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("post_abort_busy", 64'(busy), 64'd0);
         check("post_abort_hilo", 64'({HI, LO}), 64'd0);
      end

`ifdef MDU_MADD_EN
      run_md(3'd4, 32'd0, 32'd0, 1'b0);
      run_md(3'd5, 32'd10, 32'd0, 1'b0);
      run_md(3'd6, 32'd3, 32'd4, 1'b0);
      check("tp_madd", 64'({HI, LO}), 64'd22);
`else
      run_md(3'd6, 32'd3, 32'd4, 1'b0);
      check("tp_madd_off", 64'({HI, LO}), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/e_alu_mdu.md
Name: e_alu_mdu

Overview:
- Parametrised successor of the execute-stage ALU. Keeps the combinational ALU datapath, generalised to WIDTH bits, and adds shift/logic ops and signed-overflow detection.
- Adds a multi-cycle multiply/divide unit (MDU) with HI/LO registers and a busy handshake.
- Sits in the E stage; hazard unit stalls D on (start | busy) when the instruction in D is an MDU op.

Parameters:
- WIDTH, 32, datapath width (even, >=8).
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- A  in  WIDTH  operand A (rs).
- B  in  WIDTH  operand B (rt/imm).
- shamt  in  $clog2(WIDTH)  shift amount.
- ALUop  in  4  combinational ALU op select.
- ALUresult  out  WIDTH  combinational ALU result.
- overflow  out  1  signed overflow of add/sub (combinational).
- start  in  1  MDU command strobe, sampled at posedge.
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- busy  out  1  MDU operation in progress.
- HI  out  WIDTH  HI register (mfhi source).
- LO  out  WIDTH  LO register (mflo source).

Behaviour:
- ALU ops (pure combinational, no clock/reset dependence):
  - 0 A+B; 1 A-B; 2 B<<(WIDTH/2); 3 A|B; 4 A&B.
  - 5 signed A<B (zero-extended 1/0); 6 unsigned A<B.
  - 7 A^B; 8 ~(A|B).
  - 9 B<<shamt; 10 B>>shamt logical; 11 B>>>shamt arithmetic.
  - 12-15 result 0.
- overflow: for ALUop 0/1, set when the WIDTH+1-bit sign-extended result has bit[WIDTH] != bit[WIDTH-1]. 0 for all other ops.
- Reset: busy=0, HI=0, LO=0, internal counter=0, latched operands cleared. Reset asserted mid-operation aborts it; no HI/LO update after release.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down from LAT-1.
- IDLE + start with md_op 0-3 (and 6-7 when enabled):
  - Latch A, B, md_op; go to RUN.
  - Counter = LAT-1 (LAT = MULT_CYCLES or DIV_CYCLES); busy=1 from the next cycle.
- RUN: decrement each cycle. On the edge where counter==0, write HI/LO and return to IDLE; busy is 0 from that edge. busy is high for exactly LAT cycles.
- mthi/mtlo in IDLE: HI<=A or LO<=A at that edge; no busy.
- start while busy: ignored entirely, including mthi/mtlo. The hazard unit guarantees this does not occur; the bench checks that it is harmless.
- HI/LO hold their old values during RUN; the final values appear only at completion.
- mult: {HI,LO} = signed 2*WIDTH product. multu: unsigned product.
- div: LO = quotient truncated toward zero, HI = remainder with sign of dividend. divu: unsigned quotient/remainder.
- Divide by zero: LO = all ones, HI = A; full latency still applies.
- Signed div of most-negative by -1: LO = most-negative, HI = 0.
- Operands are taken from the latch at start; changes on A/B during RUN have no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: md_op 6 (madd) / 7 (maddu) accumulate the signed/unsigned product into {HI,LO} (mod 2^(2*WIDTH)), latency MULT_CYCLES.
- Undefined: md_op 6/7 are no-ops; start is ignored, busy stays 0, HI/LO unchanged.

Test Plan:
- ALUop 0, A=0x7FFFFFFF, B=1 -> ALUresult=0x80000000, overflow=1. ALUop 1, A=0x80000000, B=1 -> 0x7FFFFFFF, overflow=1. ALUop 11, B=0x80000000, shamt=4 -> 0xF8000000.
- start mult, A=0xFFFFFFFD (-3), B=7 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. Same operands with multu -> HI=0x00000006, LO=0xFFFFFFEB.
- start divu, A=100, B=7 -> busy 10 cycles, LO=14, HI=2. div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div by zero, A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678. div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mult in progress, pulse start mthi (A=0xDEAD) on cycle 2 -> ignored; final HI/LO equal the mult result. mtlo in IDLE with A=0x55 -> LO=0x55 next edge, busy stays 0.
- Start div, drop reset on cycle 4 for 1 cycle -> busy=0, HI=LO=0 immediately and stay 0. With MDU_MADD_EN, HI=0, LO=10, madd A=3, B=4 -> LO=22 after 5 cycles.
